// File: rtl/lcd_responder.sv
// HD44780-class 16x2 character-LCD responder: command decode, 80-byte DDRAM, cursor and busy timing.
// Optional macro LCD_PROTOCOL_CHECK_EN drops writes made inside the busy window and flags them.
module lcd_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lcd_on,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       busy,
    output logic       err_busy_write
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [6:0] LAST_INDEX = 7'd79;
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;

    fill_state_t   state;
    logic [6:0]    fill_idx;
    logic [CW-1:0] busy_cnt;
    logic          inc_mode;
    logic          en_q0, en_q1, rs_q0, rs_q1, rw_q0, rw_q1, on_q0, on_q1;
    logic [7:0]    data_q0, data_q1;
    logic [7:0]    ddram [0:79];

    logic fill_active, cnt_busy, fall, rd_strobe, wr_strobe, wr_blocked, wr_accept;

    // Line 1 (0x00-0x27) maps to entries 0-39, line 2 (0x40-0x67) to 40-79.
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    endfunction

    function automatic logic addr_valid(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    assign fill_active = (state == ST_FILL);
    assign cnt_busy    = (busy_cnt != '0);
    assign busy        = fill_active | cnt_busy;
    assign fall        = en_q1 & ~en_q0 & on_q1;
    assign rd_strobe   = fall & rw_q1;
    assign wr_strobe   = fall & ~rw_q1;
    assign wr_accept   = wr_strobe & ~wr_blocked;

`ifdef LCD_PROTOCOL_CHECK_EN
    assign wr_blocked = fill_active | cnt_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_busy_write <= 1'b0;
        end else if (wr_strobe && cnt_busy) begin
            err_busy_write <= 1'b1;
        end
    end
`else
    assign wr_blocked     = fill_active;
    assign err_busy_write = 1'b0;
`endif

    assign lcd_data_oe = lcd_on & en_q0 & rw_q0;

    always_comb begin
        lcd_data_out = 8'h00;
        if (lcd_data_oe) begin
            lcd_data_out = rs_q0 ? ddram[ddram_index(cursor_addr)] : {busy, cursor_addr};
        end
    end

    always_comb begin
        dbg_char = 8'h00;
        if (addr_valid(dbg_addr)) begin
            dbg_char = ddram[ddram_index(dbg_addr)];
        end
    end

    // Storage has no reset; the fill sequence started by reset blanks it.
    always_ff @(posedge clock) begin
        if (fill_active) begin
            ddram[fill_idx] <= BLANK;
        end else if (wr_accept && rs_q1) begin
            ddram[ddram_index(cursor_addr)] <= data_q1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q0       <= 1'b0;
            en_q1       <= 1'b0;
            rs_q0       <= 1'b0;
            rs_q1       <= 1'b0;
            rw_q0       <= 1'b0;
            rw_q1       <= 1'b0;
            on_q0       <= 1'b0;
            on_q1       <= 1'b0;
            data_q0     <= 8'h00;
            data_q1     <= 8'h00;
            state       <= ST_FILL;
            fill_idx    <= 7'd0;
            busy_cnt    <= '0;
            cursor_addr <= 7'h00;
            inc_mode    <= 1'b1;
            display_on  <= 1'b0;
        end else begin
            en_q0   <= lcd_en;
            en_q1   <= en_q0;
            rs_q0   <= lcd_rs;
            rs_q1   <= rs_q0;
            rw_q0   <= lcd_rw;
            rw_q1   <= rw_q0;
            on_q0   <= lcd_on;
            on_q1   <= on_q0;
            data_q0 <= lcd_data_in;
            data_q1 <= data_q0;

            if (state == ST_FILL) begin
                fill_idx <= fill_idx + 7'd1;
                if (fill_idx == LAST_INDEX) state <= ST_IDLE;
            end
            if (cnt_busy) busy_cnt <= busy_cnt - CW'(1);

            if (rd_strobe && rs_q1) cursor_addr <= addr_step(cursor_addr, inc_mode);

            if (wr_accept) begin
                if (rs_q1) begin
                    cursor_addr <= addr_step(cursor_addr, inc_mode);
                    busy_cnt    <= BUSY_LOAD;
                end else begin
                    casez (data_q1)
                        8'b1???????: begin
                            cursor_addr <= addr_valid(data_q1[6:0]) ? data_q1[6:0] : 7'h00;
                            busy_cnt    <= BUSY_LOAD;
                        end
                        8'b01??????, 8'b001?????, 8'b0001????: busy_cnt <= BUSY_LOAD;
                        8'b00001???: begin
                            display_on <= data_q1[2];
                            busy_cnt   <= BUSY_LOAD;
                        end
                        8'b000001??: begin
                            inc_mode <= data_q1[1];
                            busy_cnt <= BUSY_LOAD;
                        end
                        8'b0000001?: begin
                            cursor_addr <= 7'h00;
                            busy_cnt    <= CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            cursor_addr <= 7'h00;
                            inc_mode    <= 1'b1;
                            busy_cnt    <= CLEAR_LOAD;
                            state       <= ST_FILL;
                            fill_idx    <= 7'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
